// File: rtl/tft_spi_rx.sv
// Display-side SPI mode-0 slave for the TFT link: oversamples the SPI pins on MasterCLK,
// assembles RS-tagged words and queues them in a small first-word-fall-through FIFO.
module tft_spi_rx #(
  parameter int unsigned WordBits  = 8,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                MasterCLK,
  input  logic                reset,
  input  logic                SPI_CLK,
  input  logic                SPI_MOSI,
  input  logic                SPI_CS,
  input  logic                RS,
  input  logic                ReadEn,
  output logic [WordBits:0]   DataOut,
  output logic                Empty,
  output logic                Full,
  output logic                Overflow,
  output logic                FrameError
);

  localparam int unsigned CntW  = $clog2(WordBits);
  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WordBits - 1);

  typedef enum logic [0:0] {StIdle, StShift} rxState_e;

  // Pin synchronisers; reset values match the idle levels of the link.
  logic sclkS1, sclkS2, sclkS3;
  logic mosiS1, mosiS2;
  logic csS1, csS2;
  logic rsS1, rsS2;
  logic rise;

  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      sclkS1 <= 1'b0;
      sclkS2 <= 1'b0;
      sclkS3 <= 1'b0;
      mosiS1 <= 1'b0;
      mosiS2 <= 1'b0;
      csS1   <= 1'b1;
      csS2   <= 1'b1;
      rsS1   <= 1'b0;
      rsS2   <= 1'b0;
    end else begin
      sclkS1 <= SPI_CLK;
      sclkS2 <= sclkS1;
      sclkS3 <= sclkS2;
      mosiS1 <= SPI_MOSI;
      mosiS2 <= mosiS1;
      csS1   <= SPI_CS;
      csS2   <= csS1;
      rsS1   <= RS;
      rsS2   <= rsS1;
    end
  end

  assign rise = sclkS2 & ~sclkS3;

  // Receiver FSM
  rxState_e              stateQ, stateD;
  logic [CntW-1:0]       bitCntQ, bitCntD;
  logic [WordBits-2:0]   shiftQ, shiftD;
  logic [WordBits-1:0]   shiftNext;
  logic                  wrValidQ, wrValidD;
  logic [WordBits:0]     wrWordQ, wrWordD;
  logic                  frameErrQ, frameErrD;

  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      stateQ    <= StIdle;
      bitCntQ   <= '0;
      shiftQ    <= '0;
      wrValidQ  <= 1'b0;
      wrWordQ   <= '0;
      frameErrQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      bitCntQ   <= bitCntD;
      shiftQ    <= shiftD;
      wrValidQ  <= wrValidD;
      wrWordQ   <= wrWordD;
      frameErrQ <= frameErrD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    bitCntD   = bitCntQ;
    shiftD    = shiftQ;
    wrValidD  = 1'b0;
    wrWordD   = wrWordQ;
    frameErrD = 1'b0;
    shiftNext = {shiftQ, mosiS2};
    unique case (stateQ)
      StIdle: begin
        if (!csS2) begin
          bitCntD = '0;
          stateD  = StShift;
        end
      end
      StShift: begin
        // A deselect takes priority over a clock edge seen in the same cycle.
        if (csS2) begin
          frameErrD = (bitCntQ != '0);
          stateD    = StIdle;
        end else if (rise) begin
          shiftD = shiftNext[WordBits-2:0];
          if (bitCntQ == LastBit) begin
            bitCntD  = '0;
            wrValidD = 1'b1;
            wrWordD  = {rsS2, shiftNext};
          end else begin
            bitCntD = bitCntQ + CntW'(1);
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign FrameError = frameErrQ;

  // FIFO with one extra pointer bit to tell full from empty
  logic [WordBits:0] mem [FifoDepth];
  logic [PtrW-1:0]   wpQ, rpQ;
  logic              overflowQ;
  logic              push, pop;

  assign Empty    = (wpQ == rpQ);
  assign Full     = (wpQ[AddrW] != rpQ[AddrW]) && (wpQ[AddrW-1:0] == rpQ[AddrW-1:0]);
  assign DataOut  = mem[rpQ[AddrW-1:0]];
  assign Overflow = overflowQ;
  assign pop      = ReadEn & ~Empty;
  // A full FIFO still accepts a word when the head is popped on the same edge.
  assign push     = wrValidQ & (~Full | pop);

  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      wpQ       <= '0;
      rpQ       <= '0;
      overflowQ <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wpQ[AddrW-1:0]] <= wrWordQ;
        wpQ                 <= wpQ + PtrW'(1);
      end
      if (pop) begin
        rpQ <= rpQ + PtrW'(1);
      end
      if (wrValidQ && Full && !pop) begin
        overflowQ <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tft_spi_rx.sv
// Directed bench for tft_spi_rx: drives SPI frames bit by bit on MasterCLK negedges
// and compares FIFO outputs against hand-computed words.
module tb_tft_spi_rx;

  logic       MasterCLK = 1'b0;
  logic       reset     = 1'b1;
  logic       SPI_CLK   = 1'b0;
  logic       SPI_MOSI  = 1'b0;
  logic       SPI_CS    = 1'b1;
  logic       RS        = 1'b0;
  logic       ReadEn    = 1'b0;
  logic [8:0] DataOut;
  logic       Empty, Full, Overflow, FrameError;

  int total = 0;
  int bad   = 0;
  int feCount = 0;

  tft_spi_rx #(
    .WordBits (8),
    .FifoDepth(4)
  ) dut (
    .MasterCLK (MasterCLK),
    .reset     (reset),
    .SPI_CLK   (SPI_CLK),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_CS    (SPI_CS),
    .RS        (RS),
    .ReadEn    (ReadEn),
    .DataOut   (DataOut),
    .Empty     (Empty),
    .Full      (Full),
    .Overflow  (Overflow),
    .FrameError(FrameError)
  );

  always #5 MasterCLK = ~MasterCLK;

  always @(negedge MasterCLK) begin
    if (FrameError) feCount++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge MasterCLK);
  endtask

  task automatic spiBit(input logic b, input logic rsv);
    SPI_MOSI = b;
    RS       = rsv;
    cycles(4);
    SPI_CLK = 1'b1;
    cycles(4);
    SPI_CLK = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] w, input logic rsv);
    for (int i = 7; i >= 0; i--) spiBit(w[i], rsv);
  endtask

  task automatic popOne();
    ReadEn = 1'b1;
    cycles(1);
    ReadEn = 1'b0;
  endtask

  initial begin
    logic [7:0] w;

    // Reset state
    cycles(3);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_ferr", 32'(FrameError), 32'd0);
    check("rst_data", 32'(DataOut), 32'h000);
    reset = 1'b0;
    cycles(2);

    // Single command 0xA5 with latency check on the last bit
    SPI_CS = 1'b0;
    cycles(4);
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) spiBit(w[i], 1'b0);
    SPI_MOSI = w[0];
    cycles(4);
    SPI_CLK = 1'b1;
    cycles(3);
    check("single_empty_e3", 32'(Empty), 32'd1);
    cycles(1);
    check("single_empty_e4", 32'(Empty), 32'd0);
    check("single_data", 32'(DataOut), 32'h0A5);
    cycles(3);
    SPI_CLK = 1'b0;
    cycles(4);
    SPI_CS = 1'b1;
    cycles(6);
    popOne();
    check("single_pop_empty", 32'(Empty), 32'd1);

    // Burst without CS toggle
    SPI_CS = 1'b0;
    cycles(4);
    sendWord(8'h2C, 1'b0);
    sendWord(8'h12, 1'b1);
    sendWord(8'h34, 1'b1);
    sendWord(8'h56, 1'b1);
    check("burst_full", 32'(Full), 32'd1);
    check("burst_head", 32'(DataOut), 32'h02C);

    // Overflow: dropped word, then write accepted together with a pop
    sendWord(8'h78, 1'b1);
    check("ovf_set", 32'(Overflow), 32'd1);
    check("ovf_full", 32'(Full), 32'd1);
    check("ovf_head", 32'(DataOut), 32'h02C);
    w = 8'h78;
    for (int i = 7; i >= 1; i--) spiBit(w[i], 1'b1);
    SPI_MOSI = w[0];
    cycles(4);
    SPI_CLK = 1'b1;
    cycles(3);
    ReadEn = 1'b1;
    cycles(1);
    ReadEn = 1'b0;
    check("ovfpop_full", 32'(Full), 32'd1);
    check("ovfpop_head", 32'(DataOut), 32'h112);
    cycles(3);
    SPI_CLK = 1'b0;
    check("drain0", 32'(DataOut), 32'h112);
    popOne();
    check("drain1", 32'(DataOut), 32'h134);
    popOne();
    check("drain2", 32'(DataOut), 32'h156);
    popOne();
    check("drain3", 32'(DataOut), 32'h178);
    popOne();
    check("drain_empty", 32'(Empty), 32'd1);
    SPI_CS = 1'b1;
    cycles(6);
    check("ovf_sticky", 32'(Overflow), 32'd1);
    check("no_ferr_so_far", 32'(feCount), 32'd0);

    // Aborted word: 5 bits then deselect
    SPI_CS = 1'b0;
    cycles(4);
    spiBit(1'b1, 1'b0);
    spiBit(1'b0, 1'b0);
    spiBit(1'b1, 1'b0);
    spiBit(1'b1, 1'b0);
    spiBit(1'b0, 1'b0);
    cycles(2);
    SPI_CS = 1'b1;
    cycles(2);
    check("abort_ferr_e2", 32'(FrameError), 32'd0);
    cycles(1);
    check("abort_ferr_e3", 32'(FrameError), 32'd1);
    cycles(1);
    check("abort_ferr_e4", 32'(FrameError), 32'd0);
    check("abort_empty", 32'(Empty), 32'd1);
    SPI_CS = 1'b0;
    cycles(4);
    sendWord(8'h3C, 1'b1);
    SPI_CS = 1'b1;
    cycles(4);
    check("after_abort_data", 32'(DataOut), 32'h13C);
    popOne();
    check("after_abort_empty", 32'(Empty), 32'd1);

    // Reset mid-word, released with CS held low
    SPI_CS = 1'b0;
    cycles(4);
    spiBit(1'b1, 1'b0);
    spiBit(1'b1, 1'b0);
    spiBit(1'b1, 1'b0);
    reset = 1'b1;
    cycles(2);
    check("mid_rst_empty", 32'(Empty), 32'd1);
    check("mid_rst_full", 32'(Full), 32'd0);
    check("mid_rst_ovf", 32'(Overflow), 32'd0);
    check("mid_rst_ferr", 32'(FrameError), 32'd0);
    check("mid_rst_data", 32'(DataOut), 32'h000);
    reset = 1'b0;
    cycles(4);
    sendWord(8'h81, 1'b0);
    check("post_rst_data", 32'(DataOut), 32'h081);
    check("post_rst_nempty", 32'(Empty), 32'd0);
    popOne();

    // ReadEn while empty must not move the pointers
    ReadEn = 1'b1;
    cycles(2);
    ReadEn = 1'b0;
    check("rd_empty_empty", 32'(Empty), 32'd1);
    check("rd_empty_full", 32'(Full), 32'd0);
    sendWord(8'h5A, 1'b1);
    check("rd_empty_data", 32'(DataOut), 32'h15A);
    popOne();
    check("rd_empty_drain", 32'(Empty), 32'd1);

    // CS rise coincident with the last-bit rise: error, no write
    w = 8'hC3;
    for (int i = 7; i >= 1; i--) spiBit(w[i], 1'b1);
    SPI_MOSI = w[0];
    cycles(4);
    SPI_CLK = 1'b1;
    SPI_CS  = 1'b1;
    cycles(3);
    check("coinc_ferr", 32'(FrameError), 32'd1);
    cycles(1);
    check("coinc_ferr_end", 32'(FrameError), 32'd0);
    cycles(4);
    check("coinc_empty", 32'(Empty), 32'd1);
    SPI_CLK = 1'b0;
    cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tft_spi_rx.md
# tft_spi_rx

Display-side receiver for the TFT SPI link: a SPI mode-0 slave that deserialises SPI_MOSI under SPI_CS framing and captures the RS (command/data) line. Each word is tagged with its RS value and pushed into a small first-word-fall-through FIFO. It sits on the far end of the TFT SPI transmitter. It serves as the loopback and self-check target for the init sequence and pixel stream, and as a capture front-end for a display model. All logic runs on MasterCLK; the SPI pins are treated as asynchronous and oversampled.

## Interface
- WordBits, 8, bits per SPI word, MSB first; legal range 2-16
- FifoDepth, 4, FIFO entries; power of two, at least 2
- MasterCLK  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- SPI_CLK  input  1  serial clock from the transmitter; idles low
- SPI_MOSI  input  1  serial data, valid on the SPI_CLK rising edge
- SPI_CS  input  1  chip select, active low
- RS  input  1  0 = command, 1 = data; sampled with the last bit of each word
- ReadEn  input  1  pop the FIFO head; ignored when Empty=1
- DataOut  output  WordBits+1  FIFO head: bit WordBits is the RS tag, the low bits are the word
- Empty  output  1  FIFO empty
- Full  output  1  FIFO full
- Overflow  output  1  sticky; a completed word was dropped
- FrameError  output  1  one-cycle pulse: SPI_CS rose with 1..WordBits-1 bits received

## Operation
- Input conditioning:
  - SPI_CLK, SPI_MOSI, SPI_CS and RS each pass through a two-flop synchroniser.
  - A third flop on synchronised SPI_CLK gives rise = sclk_s2 & ~sclk_s3.
- Receiver FSM:
  - IDLE: leave when synchronised CS=0. Clear BitCnt to 0 and go to SHIFT.
  - SHIFT, on each detected rise:
    - Shift: ShiftReg <= {ShiftReg[WordBits-2:0], mosi_s2}; BitCnt++.
    - When BitCnt reaches WordBits-1 on a rise, the word is complete. Form {rs_s2, ShiftReg[WordBits-2:0], mosi_s2}, issue a FIFO write that cycle, and set BitCnt back to 0. Consecutive words need no CS toggle.
  - SHIFT, when synchronised CS=1:
    - If BitCnt≠0, pulse FrameError for one cycle and discard the partial word.
    - Go to IDLE.
  - CS rising and a rise in the same cycle: CS wins. The edge is ignored and no write occurs.
- FIFO:
  - Circular buffer with log2(FifoDepth)+1-bit read and write pointers.
  - Empty = (wp==rp). Full = (pointer MSBs differ and the low bits are equal).
  - DataOut = mem[rp] at all times. Its value is undefined while Empty=1.
  - Write when Full=0: accepted.
  - Write when Full=1 with a pop in the same cycle: write is accepted, occupancy unchanged.
  - Write when Full=1 and no pop: word is dropped and Overflow is set. Overflow clears only on reset.
  - ReadEn while Empty=1: no effect. Simultaneous write and pop when empty: write only.
- Reset, which may arrive mid-word:
  - FSM goes to IDLE; BitCnt=0; ShiftReg=0; pointers=0.
  - Synchroniser flops go to the idle pin values: CLK 0, MOSI 0, CS 1, RS 0.
  - Output values: Empty=1, Full=0, Overflow=0, FrameError=0, DataOut=0.
  - A word in progress at reset is lost.
  - After reset release, reception starts only after synchronised CS is seen low from IDLE. A reset released while CS is low therefore begins at the next rise, with BitCnt=0.

## Timing
- SPI_CLK high and low phases must each be at least 3 MasterCLK periods.
- SPI_MOSI and RS must be stable from 3 cycles before to 3 cycles after each SPI_CLK rise.
- Latency: the SPI_CLK rise at the pins is detected 3 MasterCLK edges later. The FIFO write happens in that detect cycle. Empty falls and DataOut is valid on the next cycle, 4 edges after the pin-level rise of the last bit.
- A pop with ReadEn=1 at edge N shows the next entry on DataOut after edge N. Full and Empty update on the same edge.
- FrameError asserts 3 edges after SPI_CS rises at the pins and lasts exactly one cycle.

## Test plan
- Single command: CS low, send 0xA5 with RS=0, CS high. Expect DataOut=9'h0A5, Empty 1→0 four cycles after the 8th rise, no FrameError. Pop with ReadEn → Empty=1.
- Burst without CS toggle: send 0x2C (RS=0), then 0x12, 0x34, 0x56 (RS=1). Expect in FIFO order 0x02C, 0x112, 0x134, 0x156, with Full=1 after the 4th.
- Overflow: with the FIFO full from the burst, send 0x78 with no reads. Expect Overflow=1 sticky and FIFO contents unchanged. Send another 0x78 while pulsing ReadEn on its write cycle → 0x178 accepted, Full stays 1.
- Aborted word: send 5 bits, then raise CS → one-cycle FrameError and nothing written. Next frame 0x3C with RS=1 → only 0x13C appears.
- Reset mid-word: assert reset after 3 bits of 0xFF. Expect all outputs at their reset values. Reset released with CS held low, then a full 0x81 with RS=0 → 0x081 received intact.
- Edge cases: ReadEn while Empty leaves the pointers unchanged. CS rise coincident with the last-bit rise produces FrameError and no write.
